// File: rtl/mem_pkg.sv
// Shared definitions for the shared memory controller: size/latency defaults,
// FSM state and operation encodings, and the address fault check.
package mem_pkg;

    localparam int DEFAULT_ADDR_W  = 9;
    localparam int DEFAULT_LATENCY = 2;
    localparam int DATA_W          = 32;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_BOTH  = 2'd2
    } op_t;

    // Byte address must be word aligned and fall inside the 2**addr_w word array.
    function automatic logic addr_fault(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/shared_mem_ctrl_if.sv
// CPU-side memory bus: request (read/write/address/data) and completion status.
interface shared_mem_ctrl_if;
    import mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/sram_array.sv
// Word storage: synchronous write, combinational read.
module sram_array
    import mem_pkg::*;
#(
    parameter int    ADDR_W    = DEFAULT_ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; its contents must survive rst and a reset
    // port would also prevent mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/shared_mem_ctrl.sv
// Fixed-latency memory controller: accepts one request from IDLE, counts out
// LATENCY cycles, then performs the access and pulses ready (and err on a fault).
module shared_mem_ctrl
    import mem_pkg::*;
#(
    parameter int    ADDR_W    = DEFAULT_ADDR_W,
    parameter int    LATENCY   = DEFAULT_LATENCY,
    parameter string INIT_FILE = ""
) (
    input logic              clk,
    input logic              rst,
    shared_mem_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    op_t               acc_op;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_fault;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // With LATENCY=1 RESP is entered on the accept edge itself, so the access
    // must use the live request; otherwise it uses the latched copy.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_op    = op_q;
        if (state_q == ST_IDLE) begin
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            if (bus.mem_read && bus.mem_write) begin
                acc_op = OP_BOTH;
            end else if (bus.mem_write) begin
                acc_op = OP_WRITE;
            end else begin
                acc_op = OP_READ;
            end
        end
        acc_fault = (acc_op == OP_BOTH) || addr_fault(acc_addr, ADDR_W);
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    op_d    = acc_op;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RESP && state_q != ST_RESP) begin
            err_d = acc_fault;
            if (!acc_fault) begin
                if (acc_op == OP_READ) begin
                    rdata_d = mem_rdata;
                end
                // A reset on this edge aborts the pending write.
                mem_we = (acc_op == OP_WRITE) && !rst;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    sram_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (acc_addr[ADDR_W+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == ST_RESP);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.err   = err_q;

endmodule
